// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Listening end of a 4-digit multiplexed seven-segment bus. Each (segment, select)
// pair is registered, must stay identical for STABLE_CYCLES edges to be accepted,
// is decoded back to BCD and stored by digit position. Once all four positions
// have been seen, the two 2-digit values are published with a one-cycle strobe.
//
// Ports:
//   clk       system clock, all state on posedge
//   rst       asynchronous active-high reset
//   segment   glyph lines, bit 0 = a .. bit 6 = g
//   select    one-hot digit enable: 0 = right LSB, 1 = right MSB,
//             2 = left LSB, 3 = left MSB
//   left      reconstructed left value (0..99)
//   right     reconstructed right value (0..99)
//   valid     one-cycle pulse, left/right updated this cycle
//   frame_err one-cycle pulse, completed frame held an undecodable glyph
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] segment,
    input  logic [3:0] select,
    output logic [6:0] left,
    output logic [6:0] right,
    output logic       valid,
    output logic       frame_err
);

    localparam logic [15:0] StableMax = 16'(STABLE_CYCLES);

    // Stage 1 pair register and its previous value
    logic [6:0] seg_q, seg_prev_q;
    logic [3:0] sel_q, sel_prev_q;

    // Stage 2 stability counter
    logic [15:0] cnt_q, cnt_d;

    // Frame assembly state
    logic [3:0][3:0] dig_q, dig_d;
    logic [3:0]      seen_q, seen_d;
    logic            err_q, err_d;

    // Outputs
    logic [6:0] left_q, left_d;
    logic [6:0] right_q, right_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;

    logic       sel_onehot;
    logic       same_pair;
    logic       accept;
    logic [6:0] glyph;
    logic [3:0] dec_digit;
    logic       dec_ok;
    logic       frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q      <= '0;
            sel_q      <= '0;
            seg_prev_q <= '0;
            sel_prev_q <= '0;
            cnt_q      <= '0;
            dig_q      <= '0;
            seen_q     <= '0;
            err_q      <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            seg_q      <= segment;
            sel_q      <= select;
            seg_prev_q <= seg_q;
            sel_prev_q <= sel_q;
            cnt_q      <= cnt_d;
            dig_q      <= dig_d;
            seen_q     <= seen_d;
            err_q      <= err_d;
            left_q     <= left_d;
            right_q    <= right_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    // Stability counter and accept strobe
    always_comb begin
        sel_onehot = (sel_q != 4'b0000) && ((sel_q & (sel_q - 4'd1)) == 4'b0000);
        same_pair  = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
        cnt_d      = cnt_q;
        accept     = 1'b0;
        if (!sel_onehot) begin
            cnt_d = '0;
        end else if (!same_pair) begin
            cnt_d = 16'd1;
        end else if (cnt_q != StableMax) begin
            cnt_d = cnt_q + 16'd1;
            // Saturation at StableMax makes this fire only once per dwell
            accept = (cnt_q == StableMax - 16'd1);
        end
    end

    // Glyph decode, exact match only
    always_comb begin
        glyph     = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
        dec_digit = 4'd0;
        dec_ok    = 1'b1;
        case (glyph)
            7'h3F:   dec_digit = 4'd0;
            7'h06:   dec_digit = 4'd1;
            7'h5B:   dec_digit = 4'd2;
            7'h4F:   dec_digit = 4'd3;
            7'h66:   dec_digit = 4'd4;
            7'h6D:   dec_digit = 4'd5;
            7'h7D:   dec_digit = 4'd6;
            7'h07:   dec_digit = 4'd7;
            7'h7F:   dec_digit = 4'd8;
            7'h6F:   dec_digit = 4'd9;
            default: dec_ok    = 1'b0;
        endcase
    end

    // Frame assembly and publication
    always_comb begin
        frame_done = (seen_q == 4'b1111);
        dig_d      = dig_q;
        seen_d     = frame_done ? 4'b0000 : seen_q;
        err_d      = frame_done ? 1'b0 : err_q;
        left_d     = left_q;
        right_d    = right_q;
        valid_d    = frame_done && !err_q;
        ferr_d     = frame_done && err_q;

        // An accept on the completion edge starts the next frame
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    dig_d[i] = dec_ok ? dec_digit : 4'd0;
                end
            end
            seen_d = seen_d | sel_q;
            if (!dec_ok) begin
                err_d = 1'b1;
            end
        end

        if (valid_d) begin
            left_d  = 7'(dig_q[3]) * 7'd10 + 7'(dig_q[2]);
            right_d = 7'(dig_q[1]) * 7'd10 + 7'(dig_q[0]);
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

endmodule
